// File: rtl/tetris_pkg.sv
// Shared board geometry, colour and operation encodings, plus the
// place_tetromino FSM state type.
package tetris_pkg;
  localparam int BOARD_W     = 10;
  localparam int BOARD_H     = 24;
  localparam int HIDDEN_ROWS = 4;
  localparam int ADDR_W      = 8;
  localparam int COLOUR_W    = 6;
  localparam logic [COLOUR_W-1:0] COLOUR_EMPTY = 6'd0;

  typedef enum logic [1:0] {
    OP_CHECK  = 2'b00,
    OP_COMMIT = 2'b01,
    OP_ERASE  = 2'b10
  } op_t;

  typedef enum logic [3:0] {
    IDLE, CHK_A0, CHK_D0, CHK_A1, CHK_D1, CHK_A2, CHK_D2, CHK_A3, CHK_D3,
    WR0, WR1, WR2, WR3, FIN
  } state_t;

  // Packs four 2-bit cell offsets so that cell i sits in bits [2i+1:2i].
  function automatic logic [7:0] pack4(input logic [1:0] c0, input logic [1:0] c1,
                                       input logic [1:0] c2, input logic [1:0] c3);
    return {c3, c2, c1, c0};
  endfunction
endpackage

// File: rtl/coord_to_addr.sv
// Board coordinate to RAM address; off-board coordinates flag oob and map to 0.
module coord_to_addr
  import tetris_pkg::*;
(
  input  logic [4:0]        x,
  input  logic [5:0]        y,
  output logic [ADDR_W-1:0] addr,
  output logic              oob
);
  logic [9:0] wide;

  // Row-major address; forced to 0 when the cell lies off the board.
  always_comb begin
    oob  = (x > 5'(BOARD_W - 1)) || (y > 6'(BOARD_H - 1));
    wide = 10'(y) * 10'd10 + 10'(x);
    if (oob) begin
      addr = 8'd0;
    end else begin
      addr = wide[ADDR_W-1:0];
    end
  end
endmodule

// File: rtl/lut.sv
// Tetromino shape/colour table: base shape per block inside a 4x4 box,
// rotated clockwise (x,y)->(3-y,x) once per rotation step.
module lut
  import tetris_pkg::*;
(
  input  logic [2:0]          block,
  input  logic [1:0]          rotation,
  output logic [7:0]          cx,
  output logic [7:0]          cy,
  output logic [COLOUR_W-1:0] colour
);
  logic [7:0] bx, by;

  // Base (rotation 0) shape; id 7 aliases the square.
  always_comb begin
    bx = 8'h00;
    by = 8'h00;
    case (block)
      3'd0:    begin bx = pack4(2'd0, 2'd1, 2'd2, 2'd3); by = pack4(2'd1, 2'd1, 2'd1, 2'd1); end
      3'd2:    begin bx = pack4(2'd1, 2'd0, 2'd1, 2'd2); by = pack4(2'd0, 2'd1, 2'd1, 2'd1); end
      3'd3:    begin bx = pack4(2'd1, 2'd2, 2'd0, 2'd1); by = pack4(2'd0, 2'd0, 2'd1, 2'd1); end
      3'd4:    begin bx = pack4(2'd0, 2'd1, 2'd1, 2'd2); by = pack4(2'd0, 2'd0, 2'd1, 2'd1); end
      3'd5:    begin bx = pack4(2'd0, 2'd0, 2'd1, 2'd2); by = pack4(2'd0, 2'd1, 2'd1, 2'd1); end
      3'd6:    begin bx = pack4(2'd2, 2'd0, 2'd1, 2'd2); by = pack4(2'd0, 2'd1, 2'd1, 2'd1); end
      default: begin bx = pack4(2'd1, 2'd2, 2'd1, 2'd2); by = pack4(2'd0, 2'd0, 2'd1, 2'd1); end
    endcase
  end

  // Closed-form rotation applied cell by cell.
  always_comb begin
    cx = 8'h00;
    cy = 8'h00;
    for (int i = 0; i < 4; i++) begin
      case (rotation)
        2'd1:    begin cx[2*i +: 2] = 2'd3 - by[2*i +: 2]; cy[2*i +: 2] = bx[2*i +: 2]; end
        2'd2:    begin cx[2*i +: 2] = 2'd3 - bx[2*i +: 2]; cy[2*i +: 2] = 2'd3 - by[2*i +: 2]; end
        2'd3:    begin cx[2*i +: 2] = by[2*i +: 2]; cy[2*i +: 2] = 2'd3 - bx[2*i +: 2]; end
        default: begin cx[2*i +: 2] = bx[2*i +: 2]; cy[2*i +: 2] = by[2*i +: 2]; end
      endcase
    end
  end

  assign colour = {block, 3'b111};
endmodule

// File: rtl/place_tetromino.sv
// Falling-piece board writer: checks the 4 target cells for collision, then
// commits the piece colour or erases the cells through board RAM port A.
module place_tetromino
  import tetris_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [2:0]          block,
  input  logic [1:0]          rotation,
  input  logic [3:0]          X_in,
  input  logic [4:0]          Y_in,
  input  logic [COLOUR_W-1:0] ram_Q,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [COLOUR_W-1:0] ram_data,
  output logic                ram_wren,
  output logic                busy,
  output logic                done,
  output logic                collision
);
  state_t state_r, state_nx;
  op_t    op_r, op_in;
  logic [2:0] block_r;
  logic [1:0] rot_r;
  logic [3:0] x_r;
  logic [4:0] y_r;
  logic       coll_r;

  logic [7:0]          cx, cy;
  logic [COLOUR_W-1:0] colour;
  logic [1:0]          idx;
  logic                in_chk, in_dat, in_wr, accept, hit, oob;
  logic [4:0]          x_sel;
  logic [5:0]          y_sel;
  logic [ADDR_W-1:0]   addr_sel;

  lut u_lut (.block(block_r), .rotation(rot_r), .cx(cx), .cy(cy), .colour(colour));

  assign op_in  = (op == 2'b10) ? OP_ERASE : ((op == 2'b01) ? OP_COMMIT : OP_CHECK);
  assign accept = start && ((state_r == IDLE) || (state_r == FIN));

  // Decode the active cell index and phase from the state.
  always_comb begin
    idx    = 2'd0;
    in_chk = 1'b0;
    in_dat = 1'b0;
    in_wr  = 1'b0;
    case (state_r)
      CHK_A0:  begin idx = 2'd0; in_chk = 1'b1; end
      CHK_D0:  begin idx = 2'd0; in_chk = 1'b1; in_dat = 1'b1; end
      CHK_A1:  begin idx = 2'd1; in_chk = 1'b1; end
      CHK_D1:  begin idx = 2'd1; in_chk = 1'b1; in_dat = 1'b1; end
      CHK_A2:  begin idx = 2'd2; in_chk = 1'b1; end
      CHK_D2:  begin idx = 2'd2; in_chk = 1'b1; in_dat = 1'b1; end
      CHK_A3:  begin idx = 2'd3; in_chk = 1'b1; end
      CHK_D3:  begin idx = 2'd3; in_chk = 1'b1; in_dat = 1'b1; end
      WR0:     begin idx = 2'd0; in_wr = 1'b1; end
      WR1:     begin idx = 2'd1; in_wr = 1'b1; end
      WR2:     begin idx = 2'd2; in_wr = 1'b1; end
      WR3:     begin idx = 2'd3; in_wr = 1'b1; end
      default: begin idx = 2'd0; end
    endcase
  end

  assign x_sel = 5'(x_r) + 5'(cx[{idx, 1'b0} +: 2]);
  assign y_sel = 6'(y_r) + 6'(cy[{idx, 1'b0} +: 2]);

  coord_to_addr u_addr (.x(x_sel), .y(y_sel), .addr(addr_sel), .oob(oob));

  assign hit = in_dat && ((ram_Q != COLOUR_EMPTY) || oob);

  // Next-state logic; FIN may chain straight into a new operation.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE, FIN: begin
        if (start) begin
          state_nx = (op_in == OP_ERASE) ? WR0 : CHK_A0;
        end else begin
          state_nx = IDLE;
        end
      end
      CHK_A0:  state_nx = CHK_D0;
      CHK_D0:  state_nx = CHK_A1;
      CHK_A1:  state_nx = CHK_D1;
      CHK_D1:  state_nx = CHK_A2;
      CHK_A2:  state_nx = CHK_D2;
      CHK_D2:  state_nx = CHK_A3;
      CHK_A3:  state_nx = CHK_D3;
      CHK_D3: begin
        if ((op_r == OP_COMMIT) && !(coll_r || hit)) begin
          state_nx = WR0;
        end else begin
          state_nx = FIN;
        end
      end
      WR0:     state_nx = WR1;
      WR1:     state_nx = WR2;
      WR2:     state_nx = WR3;
      WR3:     state_nx = FIN;
      default: state_nx = IDLE;
    endcase
  end

  // State register, operand latch and collision accumulator.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
      op_r    <= OP_CHECK;
      block_r <= 3'd0;
      rot_r   <= 2'd0;
      x_r     <= 4'd0;
      y_r     <= 5'd0;
      coll_r  <= 1'b0;
    end else begin
      state_r <= state_nx;
      if (accept) begin
        op_r    <= op_in;
        block_r <= block;
        rot_r   <= rotation;
        x_r     <= X_in;
        y_r     <= Y_in;
        coll_r  <= 1'b0;
      end else if (hit) begin
        coll_r  <= 1'b1;
      end else begin
        coll_r  <= coll_r;
      end
    end
  end

  assign ram_addr  = (in_chk || in_wr) ? addr_sel : 8'd0;
  assign ram_wren  = in_wr && !oob;
  assign ram_data  = (in_wr && (op_r == OP_COMMIT)) ? colour : COLOUR_EMPTY;
  assign busy      = (state_r != IDLE) && (state_r != FIN);
  assign done      = (state_r == FIN);
  assign collision = coll_r;
endmodule
